// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the pipeline sequencer and the stage registers.
// The master side drives the event inputs; the slave side is the sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned STAT_W = 16
);
    logic              branch_taken;
    logic              raw_hazard;
    logic              mem_access;
    logic              clr_stats;
    logic              freeze_front;
    logic              freeze_back;
    logic              flush_if;
    logic              flush_id;
    logic              mem_busy;
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] flush_events;

    modport master (
        output branch_taken, raw_hazard, mem_access, clr_stats,
        input  freeze_front, freeze_back, flush_if, flush_id, mem_busy,
               stall_cycles, flush_events
    );

    modport slave (
        input  branch_taken, raw_hazard, mem_access, clr_stats,
        output freeze_front, freeze_back, flush_if, flush_id, mem_busy,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: resolves branch flushes, RAW bubbles and data-memory
// wait states into freeze/flush controls, and keeps saturating statistics.
module pipeline_ctrl #(
    parameter int unsigned MEM_WAIT_CYCLES = 5,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned STAT_W          = 16
) (
    input logic             clk,
    input logic             rst,
    pipeline_ctrl_if.slave  bus
);
    localparam bit               MEM_EN   = (MEM_WAIT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_WAIT_CYCLES == 0) ? '0
                                            : CNT_W'(MEM_WAIT_CYCLES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAT_W-1:0]  stall_q, flush_q;
    logic               freeze_front, freeze_back, flush_if, flush_id;
    logic               resolve;

    // State and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and zero-latency controls; branch/hazard resolution is shared
    // between RUN and the release cycle of MEM_WAIT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        resolve      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MEM_EN && bus.mem_access) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    state_d      = MEM_WAIT;
                    cnt_d        = CNT_LOAD;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != '0) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                end else begin
                    resolve = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (resolve) begin
            if (bus.branch_taken) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (bus.raw_hazard) begin
                freeze_front = 1'b1;
                flush_id     = 1'b1;
            end
        end

        if (rst) begin
            freeze_front = 1'b0;
            freeze_back  = 1'b0;
            flush_if     = 1'b0;
            flush_id     = 1'b0;
        end
    end

    // Saturating statistics; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || bus.clr_stats) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (freeze_front && (stall_q != STAT_MAX)) stall_q <= stall_q + STAT_W'(1);
            if (flush_if && (flush_q != STAT_MAX))     flush_q <= flush_q + STAT_W'(1);
        end
    end

    assign bus.freeze_front = freeze_front;
    assign bus.freeze_back  = freeze_back;
    assign bus.flush_if     = flush_if;
    assign bus.flush_id     = flush_id;
    assign bus.mem_busy     = (state_q == MEM_WAIT) && !rst;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
endmodule
